blue_sprite_addr: RTL and testbench

Address and animation sequencer for the blue character sprite; it drives the side of the sprite-pixel path that reads the sprite ROMs. It maps the VGA scan position against the character's screen position, mirrors the column for left-facing states, and advances the 4-step animation frame (ROM images 1/5/9/13). It outputs the ROM address, hit flag, frame select and latched state that the pixel-select logic uses. Sprite is 47 columns × 41 rows, row-major, address = row*47 + col, range 0..1926.

---
 rtl/blue_sprite_addr.sv | 149 ++++++++++++++
 tb/tb_blue_sprite_addr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/blue_sprite_addr.sv
`default_nettype none
// ============================================================================
// Module   : blue_sprite_addr
// Purpose  : Address and animation sequencer for the blue character sprite.
//            Maps the VGA scan position onto the 47x41 sprite box, mirrors
//            the column for left-facing states, and steps the 4-image
//            animation frame (ROM images 1/5/9/13). Frame select and facing
//            state are latched only at the frame start (0,0) so a frame is
//            never drawn with a mix of two images.
// Ports    :
//   clk, rst          clock, synchronous active-high reset
//   ipcnt[31:0]       free-running tick counter; == FRAME_DIV is a step event
//   hcount/vcount     VGA scan column/row
//   pos_x/pos_y       sprite top-left corner on screen
//   state_in[2:0]     requested state {dir, jump, walk}
//   blue[10:0]        sprite ROM address (row*SPR_W + col), 0 outside box
//   blue_hit          scan pixel lies inside the sprite box
//   blue_frame[1:0]   animation frame select (0->img1 .. 3->img13)
//   blue_state[2:0]   state latched at frame start
// Revision : 1.0 - initial release
// ============================================================================
module blue_sprite_addr #(
  parameter int SPR_W     = 47,
  parameter int SPR_H     = 41,
  parameter int FRAME_DIV = 6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ipcnt,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [2:0]  state_in,
  output logic [10:0] blue,
  output logic        blue_hit,
  output logic [1:0]  blue_frame,
  output logic [2:0]  blue_state
);

  // All box arithmetic is done at 11 bits so pos+size never wraps past 1023.
  localparam logic [10:0] C_SPR_W     = 11'(SPR_W);
  localparam logic [10:0] C_SPR_H     = 11'(SPR_H);
  localparam logic [31:0] C_FRAME_DIV = 32'(FRAME_DIV);

  localparam logic [2:0]  C_R_STATIC  = 3'b000;
  localparam logic [2:0]  C_R_BAD     = 3'b011;
  localparam logic [2:0]  C_L_STATIC  = 3'b100;
  localparam logic [2:0]  C_L_BAD     = 3'b111;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  frame_next_q, frame_next_d;
  logic [2:0]  prev_state_q, prev_state_d;
  logic [1:0]  blue_frame_q, blue_frame_d;
  logic [2:0]  blue_state_q, blue_state_d;
  logic [10:0] blue_q,       blue_d;
  logic        blue_hit_q,   blue_hit_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [2:0]  w_state;
  logic        w_step;
  logic        w_frame_start;
  logic [10:0] w_h, w_v, w_px, w_py;
  logic [10:0] w_dx, w_dy, w_col, w_addr;
  logic        w_inside;

  // Undefined walk+jump codes collapse to static of the same direction.
  always_comb begin
    w_state = state_in;
    if (state_in == C_R_BAD) w_state = C_R_STATIC;
    if (state_in == C_L_BAD) w_state = C_L_STATIC;
  end

  always_comb begin
    w_step        = (ipcnt == C_FRAME_DIV);
    w_frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  end

  // Animation step. A state change restarts the cycle at frame 0 and wins
  // over a simultaneous step event. Jump states pin the frame at 0.
  always_comb begin
    frame_next_d = frame_next_q;
    prev_state_d = prev_state_q;
    if (w_state != prev_state_q) begin
      frame_next_d = 2'd0;
      prev_state_d = w_state;
    end else if (w_step) begin
      if (w_state[1]) frame_next_d = 2'd0;
      else            frame_next_d = frame_next_q + 2'd1;
    end
  end

  // Frame-start latch uses the values registered before this cycle, so the
  // whole visible frame sees one consistent image and facing.
  always_comb begin
    blue_frame_d = blue_frame_q;
    blue_state_d = blue_state_q;
    if (w_frame_start) begin
      blue_frame_d = frame_next_q;
      blue_state_d = prev_state_q;
    end
  end

  // Address generation. Mirroring keys off the latched state, not state_in.
  always_comb begin
    w_h      = {1'b0, hcount};
    w_v      = {1'b0, vcount};
    w_px     = {1'b0, pos_x};
    w_py     = {1'b0, pos_y};
    w_dx     = w_h - w_px;
    w_dy     = w_v - w_py;
    w_inside = (w_h >= w_px) && (w_h < (w_px + C_SPR_W)) &&
               (w_v >= w_py) && (w_v < (w_py + C_SPR_H));
    w_col    = blue_state_q[2] ? (C_SPR_W - 11'd1 - w_dx) : w_dx;
    // Max in-box value is 1926, so 11 bits hold the result exactly.
    w_addr   = (w_dy * C_SPR_W) + w_col;
    blue_hit_d = w_inside;
    blue_d     = w_inside ? w_addr : 11'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_next_q <= 2'd0;
      prev_state_q <= 3'b000;
      blue_frame_q <= 2'd0;
      blue_state_q <= 3'b000;
      blue_q       <= 11'd0;
      blue_hit_q   <= 1'b0;
    end else begin
      frame_next_q <= frame_next_d;
      prev_state_q <= prev_state_d;
      blue_frame_q <= blue_frame_d;
      blue_state_q <= blue_state_d;
      blue_q       <= blue_d;
      blue_hit_q   <= blue_hit_d;
    end
  end

  assign blue       = blue_q;
  assign blue_hit   = blue_hit_q;
  assign blue_frame = blue_frame_q;
  assign blue_state = blue_state_q;

endmodule
`default_nettype wire

// File: tb/tb_blue_sprite_addr.sv
`default_nettype none
// ============================================================================
// Module   : tb_blue_sprite_addr
// Purpose  : Directed self-checking bench for blue_sprite_addr. Inputs change
//            1 time unit after the rising edge; outputs are checked at that
//            same point, i.e. after the edge that registered them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blue_sprite_addr;

  localparam logic [31:0] C_DIV = 32'd6000000;

  logic        clk;
  logic        rst;
  logic [31:0] ipcnt;
  logic [9:0]  hcount, vcount, pos_x, pos_y;
  logic [2:0]  state_in;
  logic [10:0] blue;
  logic        blue_hit;
  logic [1:0]  blue_frame;
  logic [2:0]  blue_state;

  int tests;
  int fails;

  blue_sprite_addr #(.SPR_W(47), .SPR_H(41), .FRAME_DIV(6000000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ipcnt      (ipcnt),
    .hcount     (hcount),
    .vcount     (vcount),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .state_in   (state_in),
    .blue       (blue),
    .blue_hit   (blue_hit),
    .blue_frame (blue_frame),
    .blue_state (blue_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle with scan at (0,0), then scan back to a neutral spot.
  task automatic frame_start();
    hcount = 10'd0; vcount = 10'd0;
    tick();
    hcount = 10'd5; vcount = 10'd5;
  endtask

  // One cycle with a step event.
  task automatic step();
    ipcnt = C_DIV;
    tick();
    ipcnt = 32'd0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; ipcnt = 32'd0; hcount = 10'd5; vcount = 10'd5;
    pos_x = 10'd100; pos_y = 10'd200; state_in = 3'b000;
    tick(); tick();
    check("rst_blue",  32'(blue), 32'd0);
    check("rst_hit",   32'(blue_hit), 32'd0);
    check("rst_frame", 32'(blue_frame), 32'd0);
    check("rst_state", 32'(blue_state), 32'd0);
    rst = 1'b0;

    // Right-facing address, one-cycle latency
    hcount = 10'd110; vcount = 10'd205;
    tick();
    check("right_addr", 32'(blue), 32'd245);
    check("right_hit",  32'(blue_hit), 32'd1);

    // Box edges
    hcount = 10'd146; vcount = 10'd240; tick();
    check("corner_addr", 32'(blue), 32'd1926);
    check("corner_hit",  32'(blue_hit), 32'd1);
    hcount = 10'd147; vcount = 10'd240; tick();
    check("right_out_addr", 32'(blue), 32'd0);
    check("right_out_hit",  32'(blue_hit), 32'd0);
    hcount = 10'd99; vcount = 10'd205; tick();
    check("left_out_addr", 32'(blue), 32'd0);
    check("left_out_hit",  32'(blue_hit), 32'd0);
    hcount = 10'd146; vcount = 10'd241; tick();
    check("bottom_out_hit", 32'(blue_hit), 32'd0);
    hcount = 10'd100; vcount = 10'd199; tick();
    check("top_out_hit", 32'(blue_hit), 32'd0);
    pos_x = 10'd1000; hcount = 10'd5; vcount = 10'd205; tick();
    check("nowrap_hit",  32'(blue_hit), 32'd0);
    check("nowrap_addr", 32'(blue), 32'd0);
    pos_x = 10'd100;

    // Left mirroring: state must reach prev_state, then be latched at frame start
    state_in = 3'b100; tick();
    check("state_before_fs", 32'(blue_state), 32'd0);
    frame_start();
    check("left_state", 32'(blue_state), 32'd4);
    hcount = 10'd110; vcount = 10'd205; tick();
    check("left_addr", 32'(blue), 32'd271);
    check("left_hit",  32'(blue_hit), 32'd1);
    hcount = 10'd100; tick();
    check("left_edge_addr", 32'(blue), 32'd281);

    // Walk animation: 1,2,3,0
    state_in = 3'b001; tick();
    frame_start();
    check("walk_state", 32'(blue_state), 32'd1);
    check("walk_f0",    32'(blue_frame), 32'd0);
    step();
    check("no_tear", 32'(blue_frame), 32'd0);
    frame_start(); check("walk_f1", 32'(blue_frame), 32'd1);
    step(); frame_start(); check("walk_f2", 32'(blue_frame), 32'd2);
    step(); frame_start(); check("walk_f3", 32'(blue_frame), 32'd3);
    step(); frame_start(); check("walk_f4", 32'(blue_frame), 32'd0);

    // Near-miss tick value is not a step event
    ipcnt = C_DIV - 32'd1; tick(); ipcnt = 32'd0;
    frame_start(); check("nearmiss_frame", 32'(blue_frame), 32'd0);

    // State change beats a simultaneous step
    step(); step();
    frame_start(); check("pre_change_frame", 32'(blue_frame), 32'd2);
    state_in = 3'b010; ipcnt = C_DIV; tick(); ipcnt = 32'd0;
    frame_start();
    check("change_frame", 32'(blue_frame), 32'd0);
    check("change_state", 32'(blue_state), 32'd2);
    step(); frame_start();
    check("jump_hold1", 32'(blue_frame), 32'd0);
    step(); frame_start();
    check("jump_hold2", 32'(blue_frame), 32'd0);

    // Sanitising
    state_in = 3'b111; tick(); frame_start();
    check("san_111", 32'(blue_state), 32'd4);
    state_in = 3'b011; tick(); frame_start();
    check("san_011", 32'(blue_state), 32'd0);

    // Left walk advanced, then reset mid-line
    state_in = 3'b101; tick(); step(); frame_start();
    check("lwalk_frame", 32'(blue_frame), 32'd1);
    check("lwalk_state", 32'(blue_state), 32'd5);
    hcount = 10'd110; vcount = 10'd205; tick();
    check("pre_rst_addr", 32'(blue), 32'd271);
    rst = 1'b1; tick();
    check("mid_rst_blue",  32'(blue), 32'd0);
    check("mid_rst_hit",   32'(blue_hit), 32'd0);
    check("mid_rst_frame", 32'(blue_frame), 32'd0);
    check("mid_rst_state", 32'(blue_state), 32'd0);
    rst = 1'b0; tick();
    check("post_rst_addr",  32'(blue), 32'd245);
    check("post_rst_state", 32'(blue_state), 32'd0);
    frame_start();
    check("post_rst_fs_state", 32'(blue_state), 32'd5);
    check("post_rst_fs_frame", 32'(blue_frame), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
